// File: rtl/ws2812_bit_decoder_pkg.sv
// Shared types and default tick constants for the WS2812 receive pipeline.
// Pulse widths and counter values are measured in 100 ns ticks.
package ws2812_bit_decoder_pkg;

    // Edge flags from the pulse-width counter, one cycle wide
    typedef struct packed {
        logic rising;
        logic falling;
    } edges_t;

    // Counter snapshot: ticks since the last edge, saturating at 512
    typedef struct packed {
        logic [9:0] counter;
    } decoder_input_t;

    // One pixel in wire order; the first received bit lands in g[7]
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    // Pixel plus its frame-start tag, as held in the output register
    typedef struct packed {
        logic   frame_start;
        pixel_t pixel;
    } pixel_out_t;

    typedef enum logic [1:0] {
        SYNC,
        LOW_IDLE,
        HIGH,
        LOW
    } decoder_state_e;

    localparam int unsigned T1H_MIN    = 6;
    localparam int unsigned GLITCH     = 2;
    localparam int unsigned HIGH_MAX   = 12;
    localparam int unsigned RESET      = 500;
    localparam int unsigned PIXEL_BITS = 24;

endpackage

// File: rtl/ws2812_bit_decoder_pixel_out_reg.sv
// Single-entry valid/ready output register. A load arriving while the
// register is full and not draining is dropped and flagged with a
// one-cycle overflow pulse; the held entry is left untouched.
module pixel_out_reg #(
    parameter type payload_t = logic [23:0]
) (
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  logic     i_load,
    input  payload_t i_data,
    output payload_t o_data,
    output logic     o_valid,
    input  logic     i_ready,
    output logic     o_accepted,
    output logic     o_overflow
);

    // A load is taken when the slot is empty or drains this same cycle
    assign o_accepted = i_load & (~o_valid | i_ready);

    // Hold the payload until it is transferred; flag dropped loads
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_load & o_valid & ~i_ready;
            if (o_accepted) begin
                o_data  <= i_data;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ws2812_bit_decoder.sv
// WS2812 bit decoder: classifies high pulses into bits, assembles 24-bit
// GRB pixels MSB-first, detects line reset and presents pixels over a
// valid/ready handshake.
// Optional build macro WS2812_DECODER_STATS_EN adds o_frame_pixels, the
// count of pixels accepted by the sink during the previous frame.
module ws2812_bit_decoder
    import ws2812_bit_decoder_pkg::*;
#(
    parameter int unsigned T1H_MIN_TICKS  = T1H_MIN,
    parameter int unsigned GLITCH_TICKS   = GLITCH,
    parameter int unsigned HIGH_MAX_TICKS = HIGH_MAX,
    parameter int unsigned RESET_TICKS    = RESET
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  edges_t         i_edges,
    input  decoder_input_t i_decoder_input,
    output logic [23:0]    o_pixel,
    output logic           o_pixel_valid,
    input  logic           i_pixel_ready,
    output logic           o_frame_start,
    output logic           o_error,
    output logic           o_overflow
`ifdef WS2812_DECODER_STATS_EN
    ,
    output logic [15:0]    o_frame_pixels
`endif
);

    localparam logic [9:0] T1H_W      = 10'(T1H_MIN_TICKS);
    localparam logic [9:0] GLITCH_W   = 10'(GLITCH_TICKS);
    localparam logic [9:0] HIGH_MAX_W = 10'(HIGH_MAX_TICKS);
    localparam logic [9:0] RESET_W    = 10'(RESET_TICKS);
    localparam logic [4:0] LAST_BIT   = 5'(PIXEL_BITS - 1);

    decoder_state_e state_q, state_d;
    logic [23:0]    shift_q, shift_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic           frame_first_q;
    logic           error_q, error_d;
    logic           load;
    logic           line_reset;
    logic           accepted;
    logic [9:0]     cnt;
    logic           both_edges;
    pixel_out_t     load_data;
    pixel_out_t     out_data;

    assign cnt        = i_decoder_input.counter;
    assign both_edges = i_edges.rising & i_edges.falling;

    // State, shift register and bit counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= SYNC;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            error_q   <= error_d;
        end
    end

    // Pulse classification, bit assembly and line-reset detection
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        error_d    = 1'b0;
        load       = 1'b0;
        line_reset = 1'b0;
        case (state_q)
            SYNC: begin
                if (cnt >= RESET_W) begin
                    line_reset = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = LOW_IDLE;
                end
            end
            LOW_IDLE: begin
                if (both_edges) begin
                    error_d = 1'b1;
                    state_d = SYNC;
                end else if (i_edges.rising) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (both_edges) begin
                    error_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SYNC;
                end else if (i_edges.falling) begin
                    if (cnt < GLITCH_W) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = SYNC;
                    end else begin
                        shift_d = {shift_q[22:0], (cnt >= T1H_W)};
                        state_d = LOW;
                        if (bit_cnt_q == LAST_BIT) begin
                            load      = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (cnt >= HIGH_MAX_W) begin
                    error_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SYNC;
                end
            end
            LOW: begin
                if (both_edges) begin
                    error_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SYNC;
                end else begin
                    // A rising edge that ends an over-long low still counts
                    // as a line reset; the new high pulse is then decoded.
                    if (cnt >= RESET_W) begin
                        line_reset = 1'b1;
                        error_d    = (bit_cnt_q != '0);
                        bit_cnt_d  = '0;
                        state_d    = LOW_IDLE;
                    end
                    if (i_edges.rising) begin
                        state_d = HIGH;
                    end
                end
            end
            default: begin
                state_d   = SYNC;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Frame-first tag: set by line reset, cleared when a pixel is loaded
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_first_q <= 1'b0;
        end else if (line_reset) begin
            frame_first_q <= 1'b1;
        end else if (accepted) begin
            frame_first_q <= 1'b0;
        end
    end

    assign load_data.frame_start = frame_first_q;
    assign load_data.pixel       = shift_d;

    pixel_out_reg #(
        .payload_t (pixel_out_t)
    ) u_out (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (load),
        .i_data     (load_data),
        .o_data     (out_data),
        .o_valid    (o_pixel_valid),
        .i_ready    (i_pixel_ready),
        .o_accepted (accepted),
        .o_overflow (o_overflow)
    );

    assign o_pixel       = out_data.pixel;
    assign o_frame_start = out_data.frame_start;
    assign o_error       = error_q;

`ifdef WS2812_DECODER_STATS_EN
    logic [15:0] running_q;
    logic [15:0] running_next;
    logic        xfer;

    assign xfer         = o_pixel_valid & i_pixel_ready;
    assign running_next = (xfer && running_q != '1) ? running_q + 16'd1 : running_q;

    // Per-frame accepted-pixel count, published and restarted on line reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            running_q      <= '0;
            o_frame_pixels <= '0;
        end else if (line_reset) begin
            o_frame_pixels <= running_next;
            running_q      <= '0;
        end else begin
            running_q      <= running_next;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_bit_decoder.sv
// Scoreboard bench for ws2812_bit_decoder: one clock per 100 ns tick,
// with a behavioural model of the upstream pulse-width counter.
module tb_ws2812_bit_decoder;
    import ws2812_bit_decoder_pkg::*;

    typedef struct packed {
        logic        fs;
        logic [23:0] px;
    } exp_t;

    logic           clk;
    logic           rst_n;
    edges_t         edges;
    decoder_input_t din;
    logic [23:0]    pixel;
    logic           valid;
    logic           ready;
    logic           fs;
    logic           err;
    logic           ovf;
`ifdef WS2812_DECODER_STATS_EN
    logic [15:0]    frame_pixels;
`endif

    exp_t        q[$];
    int          checks   = 0;
    int          fails    = 0;
    int          err_seen = 0;
    int          ovf_seen = 0;
    logic [9:0]  cnt;

    ws2812_bit_decoder dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_edges         (edges),
        .i_decoder_input (din),
        .o_pixel         (pixel),
        .o_pixel_valid   (valid),
        .i_pixel_ready   (ready),
        .o_frame_start   (fs),
        .o_error         (err),
        .o_overflow      (ovf)
`ifdef WS2812_DECODER_STATS_EN
        ,
        .o_frame_pixels  (frame_pixels)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One tick: present edges and the counter, then advance the counter model
    task automatic step(input logic r, input logic f);
        edges.rising  = r;
        edges.falling = f;
        din.counter   = cnt;
        @(posedge clk);
        #1;
        if (r || f) cnt = 10'd1;
        else if (cnt < 10'd512) cnt = cnt + 10'd1;
        edges = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b);
        step(1'b1, 1'b0);
        repeat (b ? 7 : 3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic send_pixel(input logic [23:0] d);
        for (int i = 23; i >= 0; i--) send_bit(d[i]);
    endtask

    // Monitor: count pulses and compare every transferred pixel
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_seen++;
            if (ovf) ovf_seen++;
            if (valid && ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pixel: got %0h expected none", pixel);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pixel", {8'h0, pixel}, {8'h0, e.px});
                    check("frame_start", {31'h0, fs}, {31'h0, e.fs});
                end
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ready = 1'b1;
        edges = '0;
        din   = '0;
        cnt   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_pixel", {8'h0, pixel}, 32'h0);
        check("reset_error", {31'h0, err}, 32'h0);
        check("reset_overflow", {31'h0, ovf}, 32'h0);
        rst_n = 1'b1;

        // All-ones pixel after sync, with latency check on the last bit
        idle(510);
        q.push_back('{fs: 1'b1, px: 24'hFFFFFF});
        for (int i = 0; i < 23; i++) send_bit(1'b1);
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("latency_valid", {31'h0, valid}, 32'h1);
        repeat (3) step(1'b0, 1'b0);

        // Alternating bits, then a non-first pixel of zeros
        idle(510);
        q.push_back('{fs: 1'b1, px: 24'hAAAAAA});
        send_pixel(24'hAAAAAA);
        q.push_back('{fs: 1'b0, px: 24'h000000});
        send_pixel(24'h000000);

        // Partial pixel cut by line reset
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        idle(510);
        check("partial_reset_error", err_seen, 1);
        q.push_back('{fs: 1'b1, px: 24'h5A3C81});
        send_pixel(24'h5A3C81);

        // Back-pressure: second pixel dropped, first retained
        idle(510);
        ready = 1'b0;
        q.push_back('{fs: 1'b1, px: 24'h123456});
        send_pixel(24'h123456);
        send_pixel(24'h654321);
        idle(4);
        check("overflow_count", ovf_seen, 1);
        check("held_valid", {31'h0, valid}, 32'h1);
        check("held_pixel", {8'h0, pixel}, 32'h123456);
        ready = 1'b1;
        idle(2);
        check("drained_valid", {31'h0, valid}, 32'h0);

        // Glitch pulse, then bits ignored until a line reset
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle(3);
        send_pixel(24'hFFFFFF);
        idle(510);
        q.push_back('{fs: 1'b1, px: 24'h0F0F0F});
        send_pixel(24'h0F0F0F);

        // High timeout without a falling edge
        step(1'b1, 1'b0);
        idle(19);
        step(1'b0, 1'b1);
        idle(3);
        send_pixel(24'h777777);
        idle(510);
        check("glitch_timeout_errors", err_seen, 3);
        q.push_back('{fs: 1'b1, px: 24'hC3C3C3});
        send_pixel(24'hC3C3C3);

        // Simultaneous edges abort the partial pixel
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        step(1'b1, 1'b1);
        idle(3);
        idle(510);
        check("both_edges_error", err_seen, 4);

        // Asynchronous reset mid-pixel with a pending output
        ready = 1'b0;
        send_pixel(24'hABCDEF);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("pre_reset_valid", {31'h0, valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'h0, valid}, 32'h0);
        check("async_pixel", {8'h0, pixel}, 32'h0);
        check("async_frame_start", {31'h0, fs}, 32'h0);
        check("async_bit_cnt", {27'h0, dut.bit_cnt_q}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt   = '0;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        idle(510);
        q.push_back('{fs: 1'b1, px: 24'hA5A5A5});
        send_pixel(24'hA5A5A5);

        idle(5);
        check("queue_empty", q.size(), 0);
        check("final_errors", err_seen, 4);
        check("final_overflows", ovf_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ws2812_bit_decoder.md
Name: ws2812_bit_decoder

Overview:
- Stage directly downstream of the pulse-width counter in the WS2812 receive pipeline.
- Consumes the edge flags and the tick-count snapshot, and classifies each high pulse as a 0 or 1 bit.
- Assembles bits MSB-first into 24-bit GRB pixels and detects the line-reset (latch) interval.
- Presents pixels to the pixel sink over a valid/ready handshake.

Parameters:
- T1H_MIN_TICKS, 6, high-pulse width (ticks) at or above which a bit is 1.
- GLITCH_TICKS, 2, high pulses shorter than this are protocol errors.
- HIGH_MAX_TICKS, 12, high time reaching this value is a protocol error.
- RESET_TICKS, 500, low time reaching this value is a line reset (50 us at the 100 ns tick). Must be < 512, the counter saturation point.

Ports:
- i_clk, in, 1, clock
- i_reset_n, in, 1, asynchronous active-low reset
- i_edges, in, edges_t, rising/falling single-cycle flags, same cycle the counter sees them
- i_decoder_input, in, decoder_input_t, .counter (10 b): ticks since last edge. Holds the full duration in the edge cycle.
- o_pixel, out, 24, {G,R,B}; first received bit at [23]
- o_pixel_valid, out, 1, pixel available
- i_pixel_ready, in, 1, sink accepts
- o_frame_start, out, 1, asserted with the first pixel after a line reset (qualified by valid)
- o_error, out, 1, one-cycle pulse on any protocol error
- o_overflow, out, 1, one-cycle pulse when a completed pixel is dropped

Behaviour:
- Reset (async): state SYNC; shift reg, bit_cnt (5 b), frame_first flag cleared; all outputs 0.
- Line level is tracked by edges only. States:
  - SYNC: ignore edges; when counter >= RESET_TICKS → LOW_IDLE, set frame_first.
  - LOW_IDLE: rising → HIGH; counter >= RESET_TICKS stays here.
  - HIGH:
    - On falling, w = counter: w < GLITCH_TICKS → error, SYNC. Otherwise shift in (w >= T1H_MIN_TICKS), bit_cnt++, → LOW.
    - counter >= HIGH_MAX_TICKS with no falling edge → error, SYNC.
  - LOW:
    - rising → HIGH.
    - counter >= RESET_TICKS → line reset: if bit_cnt != 0, error and discard partial bits. Clear bit_cnt, set frame_first, → LOW_IDLE.
- Simultaneous rising and falling in one cycle: error, → SYNC, partial pixel discarded.
- Pixel completion: on the falling edge that makes bit_cnt = 24, the pixel is loaded into the output register on the next clock. Latency is 1 cycle after the edge cycle. bit_cnt → 0.
- Output register (valid/ready):
  - valid holds until valid & ready.
  - o_pixel and o_frame_start stable while valid.
  - frame_first clears when loaded.
  - Load with transfer in the same cycle is allowed (full throughput).
  - Completion while valid & !ready → new pixel dropped, o_overflow pulses, existing pixel retained.
- Line reset never clears a pending output pixel.
- Counter saturation at 512: the >= comparisons stay true; no wrap handling is needed.
- o_error and o_overflow are registered, one cycle wide.

Optional Feature:
- WS2812_DECODER_STATS_EN
- Defined:
  - Adds port o_frame_pixels (16 b): pixels accepted (valid & ready) since the last line reset.
  - Latched into the output, and the running count cleared, on each line reset.
  - Saturates at 16'hFFFF. Reset value 0.
- Undefined: no port and no counter logic.

Decomposition:
- pipeline_types additions:
  - pixel_t, packed struct {g, r, b} of 8 b each.
  - decoder_state_e {SYNC, LOW_IDLE, HIGH, LOW}.
  - Default tick constants T1H_MIN, GLITCH, HIGH_MAX, RESET.
- Reuses edges_t and decoder_input_t.
- One sub-module: pixel_out_reg, a single-entry valid/ready register with overflow detect, parameterised on payload type.

Test Plan:
1. Low 500 ticks, then 24 pulses of 8 ticks high / 4 ticks low → one pixel 24'hFFFFFF, frame_start=1, valid 1 cycle after the 24th falling edge.
2. Sync, then alternating 4-tick (0) and 8-tick (1) highs starting with 1 → pixel 24'hAAAAAA. Second pixel of 4-tick highs → 24'h000000 with frame_start=0.
3. 10 bits, then low for 500 ticks → o_error pulse, no pixel. The next 24 bits give a new pixel with frame_start=1.
4. Hold i_pixel_ready=0 across two completed pixels → first retained unchanged, o_overflow pulses once. Raising ready transfers the first pixel only.
5. High pulse of 1 tick, and separately 12 ticks without a falling edge → o_error, state SYNC. Decoding resumes only after 500 low ticks.
6. Assert i_reset_n low mid-pixel with valid=1 → valid, outputs and bit_cnt go 0 immediately. Bits before reset release are ignored until sync.
